// File: rtl/i2c_master_rw_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_rw_if
// Brief    : Command/status bundle between a controller and i2c_master_rw.
// Revision : 1.0
// ============================================================================
interface i2c_master_rw_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       ack_in;
  logic [7:0] rx_data;
  logic       ack_out;
  logic       done;
  logic       err;
  logic       busy;
  logic       bus_held;

  // master = command issuer, slave = the I2C engine executing commands
  modport master (
    output cmd_valid, cmd, tx_data, ack_in,
    input  cmd_ready, rx_data, ack_out, done, err, busy, bus_held
  );

  modport slave (
    input  cmd_valid, cmd, tx_data, ack_in,
    output cmd_ready, rx_data, ack_out, done, err, busy, bus_held
  );
endinterface
`default_nettype wire

// File: rtl/i2c_master_rw.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_rw
// Brief    : Command-driven I2C master (START/WRITE/READ/STOP), open-drain SDA.
//            Define I2C_NACK_ABORT_EN to append a STOP after a NACKed WRITE.
// Revision : 1.0
// ============================================================================
module i2c_master_rw #(
  parameter int DIV = 250
) (
  input  wire logic      clk,
  input  wire logic      rst,
  i2c_master_rw_if.slave bus,
  inout  wire            SDA,
  output logic           SCL
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  QMAX = CW'(DIV - 1);

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WBIT  = 3'd2,
    S_WACK  = 3'd3,
    S_RBIT  = 3'd4,
    S_RACK  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t        state_q,   state_d;
  logic [CW-1:0] qcnt_q,    qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q,     bit_d;
  logic [7:0]    tx_q,      tx_d;
  logic [7:0]    rx_sh_q,   rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          ack_in_q,  ack_in_d;
  logic          ack_out_q, ack_out_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;
  logic          busy_q,    busy_d;
  logic          held_q,    held_d;
  logic          scl_q,     scl_d;
  logic          sda_oe_q,  sda_oe_d;
`ifdef I2C_NACK_ABORT_EN
  logic          abort_q,   abort_d;
`endif

  logic sda_in;
  logic qwrap;
  logic accept;

  assign sda_in = SDA;
  assign qwrap  = (qcnt_q == QMAX);
  assign accept = bus.cmd_valid && !busy_q;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    ack_in_d  = ack_in_q;
    ack_out_d = ack_out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    held_d    = held_q;
`ifdef I2C_NACK_ABORT_EN
    abort_d   = abort_q;
`endif

    if (state_q == S_IDLE) begin
      if (accept) begin
        qcnt_d    = '0;
        quarter_d = 2'd0;
        bit_d     = 3'd0;
        tx_d      = bus.tx_data;
        ack_in_d  = bus.ack_in;
        case (bus.cmd)
          C_START: state_d = S_START;
          C_WRITE: if (held_q) state_d = S_WBIT; else err_d = 1'b1;
          C_READ:  if (held_q) state_d = S_RBIT; else err_d = 1'b1;
          default: if (held_q) state_d = S_STOP; else err_d = 1'b1;
        endcase
      end
    end else begin
      qcnt_d = qwrap ? '0 : qcnt_q + 1'b1;
      if (qwrap) begin
        quarter_d = quarter_q + 2'd1;
        // SDA is sampled mid-high-phase of SCL, at the Q2->Q3 boundary
        if (quarter_q == 2'd2) begin
          if (state_q == S_WACK) ack_out_d = sda_in;
          if (state_q == S_RBIT) rx_sh_d   = {rx_sh_q[6:0], sda_in};
        end
        if (quarter_q == 2'd3) begin
          case (state_q)
            S_START: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              held_d  = 1'b1;
            end
            S_WBIT: begin
              tx_d = {tx_q[6:0], 1'b0};
              if (bit_q == 3'd7) state_d = S_WACK;
              else               bit_d   = bit_q + 3'd1;
            end
            S_WACK: begin
`ifdef I2C_NACK_ABORT_EN
              if (ack_out_q) begin
                state_d = S_STOP;
                abort_d = 1'b1;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
`else
              state_d = S_IDLE;
              done_d  = 1'b1;
`endif
            end
            S_RBIT: begin
              if (bit_q == 3'd7) state_d = S_RACK;
              else               bit_d   = bit_q + 3'd1;
            end
            S_RACK: begin
              state_d   = S_IDLE;
              done_d    = 1'b1;
              rx_data_d = rx_sh_q;
            end
            S_STOP: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              held_d  = 1'b0;
`ifdef I2C_NACK_ABORT_EN
              err_d   = abort_q;
              abort_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    busy_d = (state_d != S_IDLE);

    // Pin levels are derived from the next state so they change with the quarter
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    case (state_d)
      S_IDLE: if (held_d) scl_d = 1'b0;
      S_START: begin
        case (quarter_d)
          2'd0:    sda_oe_d = 1'b0;
          2'd1:    begin sda_oe_d = 1'b0; scl_d = 1'b1; end
          2'd2:    begin sda_oe_d = 1'b1; scl_d = 1'b1; end
          default: begin sda_oe_d = 1'b1; scl_d = 1'b0; end
        endcase
      end
      S_WBIT: begin
        sda_oe_d = ~tx_d[7];
        scl_d    = quarter_d[1];
      end
      S_WACK, S_RBIT: begin
        sda_oe_d = 1'b0;
        scl_d    = quarter_d[1];
      end
      S_RACK: begin
        sda_oe_d = ~ack_in_d;
        scl_d    = quarter_d[1];
      end
      S_STOP: begin
        case (quarter_d)
          2'd0:    begin sda_oe_d = 1'b1; scl_d = 1'b0; end
          2'd1:    begin sda_oe_d = 1'b1; scl_d = 1'b1; end
          default: begin sda_oe_d = 1'b0; scl_d = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      ack_in_q  <= 1'b0;
      ack_out_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      held_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
`ifdef I2C_NACK_ABORT_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      ack_in_q  <= ack_in_d;
      ack_out_q <= ack_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      held_q    <= held_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
`ifdef I2C_NACK_ABORT_EN
      abort_q   <= abort_d;
`endif
    end
  end

  assign SDA          = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL          = scl_q;
  assign bus.cmd_ready = !busy_q;
  assign bus.busy      = busy_q;
  assign bus.bus_held  = held_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.ack_out   = ack_out_q;

endmodule
`default_nettype wire
